// File: rtl/perf_counter_bank_pkg.sv
// perf_counter_bank_pkg
//   Shared configuration for the performance counter bank: default bank
//   geometry and the event index assignment used by the pipeline when it
//   drives evt_inc_i slices.
package perf_counter_bank_pkg;

   localparam int PERF_CNT_NUM   = 8;   // counters in the bank
   localparam int PERF_CNT_INC_W = 2;   // per-counter increment width
   localparam int PERF_CNT_LEN   = 64;  // counter width
   localparam int PERF_XLEN      = 32;  // CSR access width

   // Slot of each event in the evt_inc_i vector; slots 5.. are free.
   typedef enum logic [2:0] {
      PERF_EVT_CYCLE = 3'd0,
      PERF_EVT_INSTR = 3'd1,
      PERF_EVT_FLUSH = 3'd2,
      PERF_EVT_WAIT  = 3'd3,
      PERF_EVT_DECOD = 3'd4
   } perf_evt_e;

endpackage

// File: rtl/perf_counter_bank_if.sv
// perf_counter_bank_if
//   CSR-side access bus of the counter bank.
//   wr_en_i/wr_idx_i/wr_hi_i/wr_data_i : half-word counter write
//   rd_en_i/rd_idx_i/rd_hi_i           : half-word counter read request
//   rd_data_o/rd_valid_o               : registered read response
//   master = CSR unit, slave = counter bank.
interface perf_counter_bank_if #(
   parameter int XLEN  = perf_counter_bank_pkg::PERF_XLEN,
   parameter int IDX_W = $clog2(perf_counter_bank_pkg::PERF_CNT_NUM)
);
   import perf_counter_bank_pkg::*;

   logic             wr_en_i;
   logic [IDX_W-1:0] wr_idx_i;
   logic             wr_hi_i;
   logic [XLEN-1:0]  wr_data_i;
   logic             rd_en_i;
   logic [IDX_W-1:0] rd_idx_i;
   logic             rd_hi_i;
   logic [XLEN-1:0]  rd_data_o;
   logic             rd_valid_o;

   modport master (
      output wr_en_i, wr_idx_i, wr_hi_i, wr_data_i, rd_en_i, rd_idx_i, rd_hi_i,
      input  rd_data_o, rd_valid_o
   );

   modport slave (
      input  wr_en_i, wr_idx_i, wr_hi_i, wr_data_i, rd_en_i, rd_idx_i, rd_hi_i,
      output rd_data_o, rd_valid_o
   );

endinterface

// File: rtl/perf_counter_bank_cell.sv
// perf_counter_cell
//   One counter of the bank: adds inc_i each cycle unless frozen, accepts a
//   half-word load, and keeps a sticky wrap flag.
//   clk, rst    : clock, synchronous active-high reset
//   inc_i       : increment amount this cycle
//   inhibit_i   : 1 = hold value
//   wr_en_i     : load selected half (wins over the increment)
//   wr_hi_i     : 0 = bits [XLEN-1:0], 1 = bits [CNT_LEN-1:XLEN]
//   wr_data_i   : load data
//   ovf_clr_i   : clear sticky wrap flag (a same-cycle wrap wins)
//   cnt_o/ovf_o : counter value / sticky wrap flag
module perf_counter_cell import perf_counter_bank_pkg::*; #(
   parameter int CNT_LEN = PERF_CNT_LEN,
   parameter int XLEN    = PERF_XLEN,
   parameter int INC_W   = PERF_CNT_INC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INC_W-1:0]   inc_i,
   input  logic               inhibit_i,
   input  logic               wr_en_i,
   input  logic               wr_hi_i,
   input  logic [XLEN-1:0]    wr_data_i,
   input  logic               ovf_clr_i,
   output logic [CNT_LEN-1:0] cnt_o,
   output logic               ovf_o
);

   // Writes are merged in a 2*XLEN view so any CNT_LEN in XLEN/2..2*XLEN
   // works; bits above CNT_LEN-1 simply fall off.
   localparam int EXT_W = 2 * XLEN;

   logic [CNT_LEN-1:0] cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [CNT_LEN:0]   sum;
   logic [EXT_W-1:0]   wr_ext;
   logic               carry;
   logic               unused_ext;

   assign unused_ext = ^wr_ext;

   always_comb begin
      sum    = {1'b0, cnt_q} + (CNT_LEN+1)'(inc_i);
      wr_ext = EXT_W'(cnt_q);
      if (wr_hi_i) wr_ext[EXT_W-1:XLEN] = wr_data_i;
      else         wr_ext[XLEN-1:0]     = wr_data_i;
      cnt_d = cnt_q;
      carry = 1'b0;
      if (wr_en_i) begin
         cnt_d = wr_ext[CNT_LEN-1:0];
      end else if (!inhibit_i) begin
         cnt_d = sum[CNT_LEN-1:0];
         carry = sum[CNT_LEN];
      end
      ovf_d = carry | (ovf_q & ~ovf_clr_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   NUM_CNT performance counters with XLEN-wide lo/hi CSR access, per-counter
//   inhibit, sticky overflow flags and a tear-free lo->hi read snapshot.
//   clk, rst      : clock, synchronous active-high reset
//   evt_inc_i     : per-counter increment, slice k = [k*INC_W +: INC_W]
//   inhibit_we_i  : load inhibit_i into the inhibit mask
//   inhibit_i/_o  : new / current inhibit mask (1 = frozen)
//   ovf_clr_i     : per-counter sticky overflow clear
//   ovf_o         : sticky overflow flags
//   csr           : CSR read/write bus (slave side)
module perf_counter_bank import perf_counter_bank_pkg::*; #(
   parameter int NUM_CNT = PERF_CNT_NUM,
   parameter int CNT_LEN = PERF_CNT_LEN,    // XLEN/2 .. 2*XLEN
   parameter int XLEN    = PERF_XLEN,
   parameter int INC_W   = PERF_CNT_INC_W,
   parameter int IDX_W   = $clog2(NUM_CNT)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CNT*INC_W-1:0] evt_inc_i,
   input  logic                     inhibit_we_i,
   input  logic [NUM_CNT-1:0]       inhibit_i,
   output logic [NUM_CNT-1:0]       inhibit_o,
   input  logic [NUM_CNT-1:0]       ovf_clr_i,
   output logic [NUM_CNT-1:0]       ovf_o,
   perf_counter_bank_if.slave       csr
);

   localparam int EXT_W = 2 * XLEN;

   logic [NUM_CNT-1:0][CNT_LEN-1:0] cnt;
   logic [NUM_CNT-1:0]              wr_sel;
   logic [NUM_CNT-1:0]              inhibit_q;
   logic                            wr_ok;

   // Out-of-range writes and hi writes to counters without a hi half are
   // dropped entirely, so the increment still happens.
   assign wr_ok = csr.wr_en_i && (int'(csr.wr_idx_i) < NUM_CNT) &&
                  (!csr.wr_hi_i || (CNT_LEN > XLEN));

   for (genvar k = 0; k < NUM_CNT; k++) begin : g_cell
      assign wr_sel[k] = wr_ok && (csr.wr_idx_i == IDX_W'(k));
      perf_counter_cell #(
         .CNT_LEN (CNT_LEN),
         .XLEN    (XLEN),
         .INC_W   (INC_W)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .inc_i     (evt_inc_i[k*INC_W +: INC_W]),
         .inhibit_i (inhibit_q[k]),
         .wr_en_i   (wr_sel[k]),
         .wr_hi_i   (csr.wr_hi_i),
         .wr_data_i (csr.wr_data_i),
         .ovf_clr_i (ovf_clr_i[k]),
         .cnt_o     (cnt[k]),
         .ovf_o     (ovf_o[k])
      );
   end

   logic [EXT_W-1:0] rd_ext;
   logic             snap_hit;
   logic [XLEN-1:0]  rd_data_q, rd_data_d;
   logic             rd_valid_q;
   logic [XLEN-1:0]  snap_q, snap_d;
   logic [IDX_W-1:0] snap_idx_q, snap_idx_d;
   logic             snap_vld_q, snap_vld_d;

   always_comb begin
      rd_ext     = (int'(csr.rd_idx_i) < NUM_CNT) ? EXT_W'(cnt[csr.rd_idx_i]) : '0;
      snap_hit   = csr.rd_hi_i && snap_vld_q && (csr.rd_idx_i == snap_idx_q);
      rd_data_d  = rd_data_q;
      snap_d     = snap_q;
      snap_idx_d = snap_idx_q;
      snap_vld_d = snap_vld_q;
      if (csr.rd_en_i) begin
         if (!csr.rd_hi_i) begin
            // lo read freezes the matching hi half for the follow-up read
            rd_data_d  = rd_ext[XLEN-1:0];
            snap_d     = rd_ext[EXT_W-1:XLEN];
            snap_idx_d = csr.rd_idx_i;
            snap_vld_d = 1'b1;
         end else if (snap_hit) begin
            rd_data_d  = snap_q;
            snap_vld_d = 1'b0;
         end else begin
            rd_data_d  = rd_ext[EXT_W-1:XLEN];
         end
      end
      // A write to the snapshotted counter (including one landing in the
      // same cycle as its lo read) makes the shadow stale.
      if (wr_ok && (csr.wr_idx_i == snap_idx_d)) snap_vld_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inhibit_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         snap_q     <= '0;
         snap_idx_q <= '0;
         snap_vld_q <= 1'b0;
      end else begin
         if (inhibit_we_i) inhibit_q <= inhibit_i;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= csr.rd_en_i;
         snap_q     <= snap_d;
         snap_idx_q <= snap_idx_d;
         snap_vld_q <= snap_vld_d;
      end
   end

   assign inhibit_o      = inhibit_q;
   assign csr.rd_data_o  = rd_data_q;
   assign csr.rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank
//   Two banks driven with identical stimulus: A = 8 x 64-bit, B = 6 x 40-bit
//   (B also exercises out-of-range indices 6/7). Reads push expected data into
//   a scoreboard queue; a negedge monitor pops and compares on rd_valid_o.
module tb_perf_counter_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] evt;
   logic        inh_we;
   logic [7:0]  inh, ovf_clr;
   logic        wr_en, wr_hi, rd_en, rd_hi;
   logic [2:0]  wr_idx, rd_idx;
   logic [31:0] wr_data;

   logic [7:0]  inh_a, ovf_a;
   logic [5:0]  inh_b, ovf_b;
   logic        dv [2];
   logic [31:0] dd [2];
   logic [7:0]  dovf [2];
   logic [7:0]  dinh [2];

   always #5 clk = ~clk;

   perf_counter_bank_if #(.XLEN(32), .IDX_W(3)) ifa ();
   perf_counter_bank_if #(.XLEN(32), .IDX_W(3)) ifb ();

   assign ifa.wr_en_i = wr_en;   assign ifb.wr_en_i = wr_en;
   assign ifa.wr_idx_i = wr_idx; assign ifb.wr_idx_i = wr_idx;
   assign ifa.wr_hi_i = wr_hi;   assign ifb.wr_hi_i = wr_hi;
   assign ifa.wr_data_i = wr_data; assign ifb.wr_data_i = wr_data;
   assign ifa.rd_en_i = rd_en;   assign ifb.rd_en_i = rd_en;
   assign ifa.rd_idx_i = rd_idx; assign ifb.rd_idx_i = rd_idx;
   assign ifa.rd_hi_i = rd_hi;   assign ifb.rd_hi_i = rd_hi;

   assign dv[0] = ifa.rd_valid_o;  assign dv[1] = ifb.rd_valid_o;
   assign dd[0] = ifa.rd_data_o;   assign dd[1] = ifb.rd_data_o;
   assign dovf[0] = ovf_a;         assign dovf[1] = {2'b00, ovf_b};
   assign dinh[0] = inh_a;         assign dinh[1] = {2'b00, inh_b};

   perf_counter_bank #(.NUM_CNT(8), .CNT_LEN(64), .XLEN(32), .INC_W(2)) dut_a (
      .clk(clk), .rst(rst), .evt_inc_i(evt), .inhibit_we_i(inh_we), .inhibit_i(inh),
      .inhibit_o(inh_a), .ovf_clr_i(ovf_clr), .ovf_o(ovf_a), .csr(ifa)
   );

   perf_counter_bank #(.NUM_CNT(6), .CNT_LEN(40), .XLEN(32), .INC_W(2)) dut_b (
      .clk(clk), .rst(rst), .evt_inc_i(evt[11:0]), .inhibit_we_i(inh_we), .inhibit_i(inh[5:0]),
      .inhibit_o(inh_b), .ovf_clr_i(ovf_clr[5:0]), .ovf_o(ovf_b), .csr(ifb)
   );

   // ---------------- checking ----------------
   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   bit armed = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   typedef struct {
      int          due;
      int          d;
      logic [31:0] data;
      bit          lit_en;
      logic [31:0] lit;
   } exp_t;
   exp_t sb [$];

   // ---------------- reference model ----------------
   logic [63:0] m_cnt [2][8];
   logic [7:0]  m_ovf [2], m_inh [2], vis_ovf [2], vis_inh [2];
   bit          m_sv [2];
   int          m_sidx [2];
   logic [31:0] m_shadow [2];
   bit          lit_en;
   logic [31:0] lit [2];

   function automatic int ncnt(input int d); return (d == 0) ? 8 : 6; endfunction
   function automatic int clen(input int d); return (d == 0) ? 64 : 40; endfunction

   task automatic model_cycle();
      logic [63:0] v;
      logic [31:0] r;
      logic [64:0] s, modv;
      bit          wrap;
      for (int d = 0; d < 2; d++) begin
         vis_ovf[d] = m_ovf[d];
         vis_inh[d] = m_inh[d];
         if (rst) begin
            for (int k = 0; k < 8; k++) m_cnt[d][k] = 64'd0;
            m_ovf[d] = 8'd0; m_inh[d] = 8'd0; m_sv[d] = 0; m_sidx[d] = 0; m_shadow[d] = 32'd0;
            continue;
         end
         if (rd_en) begin
            v = (int'(rd_idx) < ncnt(d)) ? m_cnt[d][rd_idx] : 64'd0;
            if (!rd_hi) begin
               r = v[31:0]; m_sidx[d] = int'(rd_idx); m_shadow[d] = v[63:32]; m_sv[d] = 1;
            end else if (m_sv[d] && m_sidx[d] == int'(rd_idx)) begin
               r = m_shadow[d]; m_sv[d] = 0;
            end else begin
               r = v[63:32];
            end
            sb.push_back('{cyc + 1, d, r, lit_en, lit[d]});
         end
         modv = 65'd1 << clen(d);
         for (int k = 0; k < ncnt(d); k++) begin
            wrap = 0;
            if (wr_en && int'(wr_idx) == k) begin
               s = wr_hi ? {1'b0, wr_data, m_cnt[d][k][31:0]} : {1'b0, m_cnt[d][k][63:32], wr_data};
               s = s % modv;
            end else begin
               s = {1'b0, m_cnt[d][k]};
               if (!m_inh[d][k]) s = s + 65'(evt[2*k +: 2]);
               if (s >= modv) begin s = s - modv; wrap = 1; end
            end
            m_cnt[d][k] = s[63:0];
            m_ovf[d][k] = wrap | (m_ovf[d][k] & ~ovf_clr[k]);
         end
         if (wr_en && int'(wr_idx) < ncnt(d) && int'(wr_idx) == m_sidx[d]) m_sv[d] = 0;
         if (inh_we) m_inh[d] = inh & ((d == 0) ? 8'hFF : 8'h3F);
      end
      lit_en = 0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      bit   got [2];
      if (armed) begin
         got[0] = 0; got[1] = 0;
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            got[e.d] = 1;
            chk($sformatf("rd_valid d%0d", e.d), 64'(dv[e.d]), 64'd1);
            chk($sformatf("rd_data d%0d", e.d), 64'(dd[e.d]), 64'(e.data));
            if (e.lit_en) chk($sformatf("rd_plan d%0d", e.d), 64'(dd[e.d]), 64'(e.lit));
         end
         for (int d = 0; d < 2; d++) begin
            if (!got[d]) chk($sformatf("rd_idle d%0d", d), 64'(dv[d]), 64'd0);
            chk($sformatf("ovf d%0d", d), 64'(dovf[d]), 64'(vis_ovf[d]));
            chk($sformatf("inhibit d%0d", d), 64'(dinh[d]), 64'(vis_inh[d]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      rst = 0; evt = '0; inh_we = 0; ovf_clr = '0;
      wr_en = 0; rd_en = 0;
   endtask

   task automatic step();
      model_cycle();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic wr(input int idx, input bit hi, input logic [31:0] data);
      wr_en = 1; wr_idx = 3'(idx); wr_hi = hi; wr_data = data;
   endtask

   task automatic rd(input int idx, input bit hi, input logic [31:0] la, input logic [31:0] lb);
      rd_en = 1; rd_idx = 3'(idx); rd_hi = hi;
      lit_en = 1; lit[0] = la; lit[1] = lb;
   endtask

   initial begin
      idle();
      inh = '0; wr_idx = '0; wr_hi = 0; wr_data = '0; rd_idx = '0; rd_hi = 0;
      lit_en = 0; lit[0] = '0; lit[1] = '0;
      rst = 1; step();
      armed = 1;
      rst = 1; step();

      // reset mid-count
      wr(0, 0, 32'h1234); step();
      rd(0, 0, 32'h1234, 32'h1234); evt = 16'h0001; step();
      evt = 16'h0001; step();
      evt = 16'h0001; rst = 1; rd_en = 1; rd_idx = 3'd0; step();
      for (int i = 0; i < 8; i++) begin rd(i, 0, 32'd0, 32'd0); step(); end

      // multi-increment
      for (int i = 0; i < 3; i++) begin evt = 16'h0008; step(); end
      rd(1, 0, 32'd6, 32'd6); step();
      rd(1, 1, 32'd0, 32'd0); step();

      // wrap and sticky overflow
      wr(2, 0, 32'hFFFF_FFFF); step();
      wr(2, 1, 32'hFFFF_FFFF); step();
      rd(2, 1, 32'hFFFF_FFFF, 32'h0000_00FF); step();
      rd(2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); step();
      evt = 16'h0010; step();
      chk("wrap_ovf a", 64'(dovf[0][2]), 64'd1);
      chk("wrap_ovf b", 64'(dovf[1][2]), 64'd1);
      rd(2, 0, 32'd0, 32'd0); step();
      rd(2, 1, 32'd0, 32'd0); step();
      ovf_clr = 8'h04; step();
      chk("ovf_clr a", 64'(dovf[0][2]), 64'd0);
      chk("ovf_clr b", 64'(dovf[1][2]), 64'd0);
      wr(2, 0, 32'hFFFF_FFFF); step();
      wr(2, 1, 32'hFFFF_FFFF); step();
      evt = 16'h0010; ovf_clr = 8'h04; step();
      chk("ovf_set_wins a", 64'(dovf[0][2]), 64'd1);
      chk("ovf_set_wins b", 64'(dovf[1][2]), 64'd1);

      // snapshot
      wr(3, 0, 32'hFFFF_FFFF); step();
      wr(3, 1, 32'h0); step();
      rd(3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); evt = 16'h0040; step();
      rd(3, 1, 32'd0, 32'd0); step();
      rd(3, 1, 32'd1, 32'd1); step();

      // write / increment / read collision
      wr(0, 0, 32'h10); evt = 16'h0003; rd(0, 0, 32'd0, 32'd0); step();
      rd(0, 0, 32'h10, 32'h10); step();

      // inhibit: load cycle still uses the old mask
      inh_we = 1; inh = 8'h01; evt = 16'h0005; step();
      chk("inhibit_o a", 64'(dinh[0]), 64'h01);
      for (int i = 0; i < 3; i++) begin evt = 16'h0005; step(); end
      rd(0, 0, 32'h11, 32'h11); step();
      rd(1, 0, 32'd10, 32'd10); step();
      inh_we = 1; inh = 8'h00; step();

      // out-of-range on the 6-counter bank
      wr(6, 0, 32'h55); step();
      rd(6, 0, 32'h55, 32'h0); step();
      rd(7, 1, 32'h0, 32'h0); step();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         rst     = ($urandom_range(0, 299) == 0);
         evt     = 16'($urandom);
         inh_we  = ($urandom_range(0, 19) == 0);
         inh     = 8'($urandom);
         wr_en   = ($urandom_range(0, 5) == 0);
         wr_idx  = 3'($urandom);
         wr_hi   = 1'($urandom);
         wr_data = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
         rd_en   = 1'($urandom);
         rd_idx  = 3'($urandom);
         rd_hi   = 1'($urandom);
         ovf_clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         step();
      end

      for (int i = 0; i < 3; i++) step();
      chk("scoreboard_drain", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
- Parametrised bank of NUM_CNT hardware performance counters (cycle, instret, flush, wait, decode and future events), each CNT_LEN bits wide.
- Exposed to the CSR unit through XLEN-wide lo/hi half access.
- Successor to the fixed per-counter logic. Adds:
  - multi-count increments per cycle
  - per-counter inhibit
  - sticky overflow flags
  - a tear-free lo→hi read snapshot
- Sits beside the CSR file; event strobes come from the pipeline stages.

Parameters:
- NUM_CNT, 8: number of counters.
- CNT_LEN, 64: counter width. Legal range is XLEN/2 .. 2*XLEN.
- XLEN, 32: CSR access width.
- INC_W, 2: width of per-cycle increment per counter (0..2^INC_W-1).
- IDX_W, $clog2(NUM_CNT): counter index width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- evt_inc_i  in  NUM_CNT*INC_W  increment amount per counter this cycle; slice k is [k*INC_W +: INC_W]
- inhibit_we_i  in  1  load inhibit mask
- inhibit_i  in  NUM_CNT  new inhibit mask; 1 = counter frozen
- inhibit_o  out  NUM_CNT  current inhibit mask
- wr_en_i  in  1  counter half write strobe
- wr_idx_i  in  IDX_W  counter index to write
- wr_hi_i  in  1  0 = bits [XLEN-1:0], 1 = bits [CNT_LEN-1:XLEN]
- wr_data_i  in  XLEN  write data
- rd_en_i  in  1  read strobe
- rd_idx_i  in  IDX_W  counter index to read
- rd_hi_i  in  1  half select for read
- rd_data_o  out  XLEN  read data, registered
- rd_valid_o  out  1  rd_data_o valid
- ovf_o  out  NUM_CNT  sticky wrap flags
- ovf_clr_i  in  NUM_CNT  per-counter overflow clear

Behaviour:
- Reset (rst=1 at clk edge):
  - All counters 0, inhibit_o 0, ovf_o 0.
  - rd_data_o 0, rd_valid_o 0, snapshot invalid.
  - rst overrides every other input in that cycle.
- Increment:
  - If inhibit_o[k]=0, cnt[k] <= cnt[k] + zero-extended evt slice k, modulo 2^CNT_LEN.
  - Visible in the register one cycle after the strobe.
  - A carry out of bit CNT_LEN-1 sets ovf_o[k].
- Inhibit:
  - inhibit_we_i loads the new mask at the edge.
  - The new mask applies from the next cycle. Increments in the load cycle use the old mask.
- Write:
  - Loads the selected half of cnt[wr_idx_i]; the other half keeps its current value.
  - That counter's increment in the same cycle is dropped.
  - A write never sets ovf.
  - wr_hi_i=1 with CNT_LEN<=XLEN is ignored.
  - For the hi half, bits above CNT_LEN-1 are discarded.
  - wr_idx_i >= NUM_CNT is ignored.
- Overflow:
  - ovf_clr_i[k] clears ovf_o[k].
  - If a set and a clear hit the same cycle, set wins.
- Read:
  - Latency is 1 cycle: rd_valid_o=1 in cycle n+1 for rd_en_i in cycle n, otherwise 0.
  - Data is the counter register value during cycle n, before that cycle's increment or write.
  - Unused upper bits read 0.
  - Out-of-range index reads 0 with rd_valid_o=1.
  - rd_data_o holds its last value while rd_valid_o=0.
- Snapshot (tear-free 64-bit read):
  - A lo read of counter i captures cnt[i][CNT_LEN-1:XLEN] into a shadow register and records snap_idx=i, snap_valid=1.
  - A later hi read with idx==snap_idx and snap_valid=1 returns the shadow value and clears snap_valid.
  - Any other hi read returns the live value.
  - A write to counter snap_idx, or a lo read of another counter, replaces or invalidates the snapshot.
  - Reset invalidates the snapshot.
- Timing: no FSM beyond the snap_valid bit. The adder per counter is CNT_LEN wide, single cycle.

Decomposition:
- core_config_pkg gains PERF_CNT_NUM (=8), PERF_CNT_INC_W (=2) and a perf event index enum:
  - CYCLE=0, INSTR=1, FLUSH=2, WAIT=3, DECOD=4.
- PERF_CNT_LEN is reused for CNT_LEN.
- Sub-module perf_counter_cell:
  - one counter with increment, half-write, inhibit and overflow logic
  - instantiated NUM_CNT times with a generate loop
  - the bank owns the read mux, snapshot and inhibit register.

Test Plan:
- Reset check: assert rst mid-count with counter 0 at 0x1234 → all reads return 0, ovf_o=0, inhibit_o=0, rd_valid_o=0 during reset.
- Multi-increment: evt_inc slice 1 = 2 for 3 cycles, then lo read of counter 1 → 6. Hi read → 0.
- Wrap: write counter 2 lo=0xFFFFFFFF and hi=0xFFFFFFFF, then evt=1 → counter 2 = 0 and ovf_o[2]=1. ovf_clr_i[2] with evt=0 → 0. ovf_clr_i[2] together with a new wrap → stays 1.
- Snapshot:
  - counter 3 lo=0xFFFFFFFF, hi=0
  - read lo → 0xFFFFFFFF; the same cycle's evt=1 rolls the counter to hi=1
  - read hi → 0 (shadow)
  - second hi read → 1 (live).
- Collision: write lo of counter 0 = 0x10 while evt slice 0 = 3 and a lo read of counter 0 → read returns the old value, next read returns 0x10.
- Inhibit and width variant:
  - inhibit_i[0]=1 freezes counter 0 while counter 1 keeps counting.
  - With CNT_LEN=40: writing hi=0xFFFFFFFF reads back 0x000000FF, and wrap occurs at 2^40.
